// File: rtl/bcd_bin.sv
// Sequential packed-BCD to binary converter, one digit per clock, MS digit first.
// Optional digit checking is enabled by defining BCD_BIN_ERR_EN.
module bcd_bin #(
    parameter int DIGITS = 8,
    parameter int BIN_W  = 27
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  bcd_err
);
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [BIN_W-1:0]    acc_q, acc_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] sreg_q, sreg_d;
    logic [3:0]          digit;
    logic [BIN_W-1:0]    acc_mul;
    logic                accept;

    assign digit    = sreg_q[4*DIGITS-1 -: 4];
    assign in_ready = (state_q == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign bin_out  = bin_q;

    // acc*10 + digit; working at BIN_W bits gives the required mod 2**BIN_W wrap
    assign acc_mul = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = bcd_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d  = acc_mul;
                sreg_d = sreg_q << 4;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(DIGITS - 1)) begin
                    bin_d   = acc_mul;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
        end
    end

`ifdef BCD_BIN_ERR_EN
    logic err_q, err_d;

    // sticky across one conversion, cleared on accept
    always_comb begin
        err_d = err_q;
        if (accept) err_d = 1'b0;
        else if (state_q == CONV && digit > 4'd9) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign bcd_err = err_q && out_valid;
`else
    assign bcd_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_bin.sv
// Directed + scoreboard bench for bcd_bin (DIGITS=8, BIN_W=27).
module tb_bcd_bin;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] bcd_in;
    logic        out_valid;
    logic        out_ready;
    logic [26:0] bin_out;
    logic        bcd_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [27:0] exp_q[$];
    logic [27:0] got_q[$];

`ifdef BCD_BIN_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    bcd_bin #(.DIGITS(8), .BIN_W(27)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bcd_in   (bcd_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .bin_out  (bin_out),
        .bcd_err  (bcd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // captures each completed output handshake, sampled mid low phase
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready)
            got_q.push_back({bcd_err, bin_out});
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic accept(input logic [31:0] b, input logic [26:0] eb,
                          input logic ee, output int t);
        bit ok;
        ok = 1'b0;
        t  = 0;
        @(negedge clk);
        #1;
        bcd_in   = b;
        in_valid = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                t  = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("accept_wait", 32'(ok), 32'd1);
        if (ok) exp_q.push_back({ee, eb});
    endtask

    task automatic wait_out(output int t);
        bit ok;
        ok = 1'b0;
        t  = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (out_valid) begin
                t  = cyc;
                ok = 1'b1;
                break;
            end
        end
        chk("out_wait", 32'(ok), 32'd1);
    endtask

    task automatic check_result(input string tag);
        logic [27:0] g;
        logic [27:0] e;
        #3;
        g = (got_q.size() > 0) ? got_q.pop_front() : 28'hFFFFFFF;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 28'hEEEEEEE;
        chk(tag, 32'(g), 32'(e));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_bin_out"}, 32'(bin_out), 32'd0);
        chk({tag, "_bcd_err"}, 32'(bcd_err), 32'd0);
    endtask

    initial begin
        int ta, tb2, to;
        int nv;
        logic [31:0] rb;
        int tmp;
        int n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        bcd_in    = 32'h0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        #1 rst = 1'b0;

        // zero input, latency 8
        accept(32'h00000000, 27'd0, 1'b0, ta);
        wait_out(to);
        chk("lat_zero", 32'(to - ta), 32'd8);
        check_result("res_zero");

        accept(32'h99999999, 27'h5F5E0FF, 1'b0, ta);
        wait_out(to);
        chk("lat_max", 32'(to - ta), 32'd8);
        check_result("res_max");

        // back-to-back throughput
        accept(32'h12345678, 27'h0BC614E, 1'b0, ta);
        accept(32'h00000042, 27'd42, 1'b0, tb2);
        chk("b2b_spacing", 32'(tb2 - ta), 32'd10);
        wait_out(to);
        check_result("res_b2b_a");
        check_result("res_b2b_b");

        // back-pressure in DONE
        @(negedge clk);
        #1 out_ready = 1'b0;
        accept(32'h12345678, 27'h0BC614E, 1'b0, ta);
        wait_out(to);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_bin", 32'(bin_out), 32'h0BC614E);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            #1;
            in_valid = 1'b1;
            bcd_in   = 32'h11111111;
            @(negedge clk);
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_bin_kept", 32'(bin_out), 32'h0BC614E);
        check_result("res_hold");
        @(negedge clk);
        chk("ignored_pulses", 32'(in_ready), 32'd1);
        chk("no_spurious", 32'(got_q.size()), 32'd0);

        // illegal digit
        accept(32'h0000000A, 27'd10, ERR_EXP, ta);
        wait_out(to);
        check_result("res_illegal");

        // random legal values
        for (int k = 0; k < 4; k++) begin
            nv  = int'($urandom_range(0, 99999999));
            tmp = nv;
            rb  = '0;
            for (int d = 0; d < 8; d++) begin
                rb[4*d +: 4] = 4'(tmp % 10);
                tmp = tmp / 10;
            end
            accept(rb, 27'(nv), 1'b0, ta);
            wait_out(to);
            check_result("res_rand");
        end

        // reset mid-conversion
        accept(32'h87654321, 27'd87654321, 1'b0, ta);
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk_reset_outs("midrst");
        void'(exp_q.pop_back());
        @(negedge clk);
        #1 rst = 1'b0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("midrst_no_valid", 32'(n), 32'd0);
        chk("midrst_no_result", 32'(got_q.size()), 32'd0);
        accept(32'h00000042, 27'd42, 1'b0, ta);
        wait_out(to);
        chk("lat_after_rst", 32'(to - ta), 32'd8);
        check_result("res_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
